// File: rtl/flexbex_ibex_irq_ctrl_if.sv
// flexbex_ibex_irq_ctrl_if: request/take/ack handshake between the IRQ controller and the core controller
//   irq_req_o    request to controller
//   irq_id_o     requested line index
//   csr_cause_o  mcause value {1'b1, irq_id_o}
//   irq_take_i   controller takes the trap
//   mret_i       MRET retired
//   irq_ack_o    one-cycle acknowledge to the source
//   irq_ack_id_o acknowledged line index
//   in_service_o handler active
interface flexbex_ibex_irq_ctrl_if;
   logic       irq_req_o;
   logic [4:0] irq_id_o;
   logic [5:0] csr_cause_o;
   logic       irq_take_i;
   logic       mret_i;
   logic       irq_ack_o;
   logic [4:0] irq_ack_id_o;
   logic       in_service_o;
   modport master (output irq_req_o, irq_id_o, csr_cause_o, irq_ack_o, irq_ack_id_o, in_service_o,
                   input irq_take_i, mret_i);
   modport slave  (input irq_req_o, irq_id_o, csr_cause_o, irq_ack_o, irq_ack_id_o, in_service_o,
                   output irq_take_i, mret_i);
endinterface

// File: rtl/flexbex_ibex_irq_ctrl.sv
// flexbex_ibex_irq_ctrl: synchronises, pends, prioritises and gates interrupt lines, then tracks the handler until MRET
//   clk, rst_n      clock, asynchronous active-low reset
//   irq_lines_i     asynchronous interrupt lines
//   irq_mask_i      per-line enable
//   m_irq_enable_i  mstatus.MIE
//   debug_mode_i    suppresses all requests
//   ctrl            request/take/ack handshake to the core controller (master side)
module flexbex_ibex_irq_ctrl #(
   parameter int          N_IRQ       = 32,
   parameter logic [31:0] EDGE_MASK   = 32'h0,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_IRQ-1:0]     irq_lines_i,
   input  logic [N_IRQ-1:0]     irq_mask_i,
   input  logic                 m_irq_enable_i,
   input  logic                 debug_mode_i,
   flexbex_ibex_irq_ctrl_if.master ctrl
);
   localparam logic [31:0] VALID = 32'((64'd1 << N_IRQ) - 64'd1);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
   state_e      state_q, state_d;
   logic [31:0] sync_q [SYNC_STAGES];
   logic [31:0] s, s_d_q, pending_q, pending_d, pending, clr, qual_d, qual_q;
   logic [4:0]  id_q, id_d, sel, ack_id_q;
   logic        ack_q, ack_d, gate, take;
   assign s     = sync_q[SYNC_STAGES-1];
   assign gate  = m_irq_enable_i & ~debug_mode_i;
   assign take  = (state_q == REQ) & ctrl.irq_take_i;
   assign clr   = take ? (32'd1 << id_q) : 32'd0;
   // set term is OR-ed after the clear so an edge landing on the ack edge survives
   assign pending_d = ((pending_q & ~clr) | (s & ~s_d_q)) & EDGE_MASK & VALID;
   assign pending   = (pending_q & EDGE_MASK) | (s & ~EDGE_MASK);
   assign qual_d    = pending & 32'(irq_mask_i) & VALID;
   // descending scan so the lowest set index is the last one written
   always_comb begin
      sel = '0;
      for (int k = 31; k >= 0; k--) if (qual_q[k]) sel = 5'(k);
   end
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ack_d   = 1'b0;
      case (state_q)
         IDLE: if (|qual_q && gate) begin
            state_d = REQ;
            id_d    = sel;
         end
         REQ: if (ctrl.irq_take_i) begin
            state_d = SERVICE;
            ack_d   = 1'b1;
         end else if (!gate || qual_q == 32'd0) begin
            state_d = IDLE;
         end else begin
            id_d = sel;
         end
         SERVICE: if (ctrl.mret_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // qual_q is the pipeline stage between pend and FSM decision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         s_d_q     <= '0;
         pending_q <= '0;
         qual_q    <= '0;
         state_q   <= IDLE;
         id_q      <= '0;
         ack_q     <= 1'b0;
         ack_id_q  <= '0;
      end else begin
         sync_q[0] <= 32'(irq_lines_i);
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         s_d_q     <= s;
         pending_q <= pending_d;
         qual_q    <= qual_d;
         state_q   <= state_d;
         id_q      <= id_d;
         ack_q     <= ack_d;
         ack_id_q  <= ack_d ? id_q : 5'd0;
      end
   end
   assign ctrl.irq_req_o    = state_q == REQ;
   assign ctrl.irq_id_o     = (state_q == REQ) ? id_q : 5'd0;
   assign ctrl.csr_cause_o  = (state_q == REQ) ? {1'b1, id_q} : 6'd0;
   assign ctrl.irq_ack_o    = ack_q;
   assign ctrl.irq_ack_id_o = ack_id_q;
   assign ctrl.in_service_o = state_q == SERVICE;
endmodule
